// File: rtl/hc595_pkg.sv
// rtl/hc595_pkg.sv - shared types, sizing helpers and parameter checks for the 595 chain driver
package hc595_pkg;

  // Frame sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Bits per frame for a cascade of chain_bytes devices
  function automatic int frame_bits(input int chain_bytes);
    return 8 * chain_bytes;
  endfunction

  // Counter width able to hold 0..n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Legal configurations: at least one device, even bit period of two or more cycles
  function automatic bit params_legal(input int chain_bytes, input int div);
    return (chain_bytes >= 1) && (div >= 2) && ((div % 2) == 0);
  endfunction

endpackage

// File: rtl/hc595_phase_gen.sv
// rtl/hc595_phase_gen.sv - DIV-cycle phase counter for one shifted bit or latch period
module hc595_phase_gen
  import hc595_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        en_i,
  output logic [cnt_width(DIV)-1:0]   phase_o,
  output logic [cnt_width(DIV)-1:0]   phase_nxt_o,
  output logic                        half_hi_o,
  output logic                        half_hi_nxt_o,
  output logic                        period_end_o
);

  localparam int PW = cnt_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(DIV / 2);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  // Next phase: restart on frame start, otherwise wrap 0..DIV-1 while enabled
  always_comb begin
    phase_d = phase_q;
    if (start_i) begin
      phase_d = '0;
    end else if (en_i) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    end
  end

  // Phase register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o       = phase_q;
  assign phase_nxt_o   = phase_d;
  assign half_hi_o     = (phase_q >= HALF);
  assign half_hi_nxt_o = (phase_d >= HALF);
  assign period_end_o  = (phase_q == LAST);

endmodule

// File: rtl/hc595_chain_ctrl.sv
// rtl/hc595_chain_ctrl.sv - serial shift/latch driver for a cascade of 74HC595 registers
module hc595_chain_ctrl
  import hc595_pkg::*;
#(
  parameter int CHAIN_BYTES = 2,
  parameter int DIV         = 4,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic [frame_bits(CHAIN_BYTES)-1:0] data_in,
  input  logic                              load,
  input  logic                              auto_en,
  output logic                              ready,
  output logic                              done,
  output logic                              shcp,
  output logic                              stcp,
  output logic                              ds,
  output logic                              oe_n
);

  localparam int W  = frame_bits(CHAIN_BYTES);
  localparam int BW = cnt_width(W);
  localparam int PW = cnt_width(DIV);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  if (!params_legal(CHAIN_BYTES, DIV)) begin : g_bad_params
    $error("hc595_chain_ctrl: CHAIN_BYTES must be >= 1 and DIV even and >= 2");
  end

  state_e        state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic          start;

  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          shcp_q, shcp_d;
  logic          stcp_q, stcp_d;
  logic          ds_q, ds_d;
  logic          oe_n_q, oe_n_d;

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nxt;
  logic          half_hi;
  logic          half_hi_nxt;
  logic          period_end;

  hc595_phase_gen #(
    .DIV (DIV)
  ) u_phase (
    .clk_i         (sys_clk),
    .rst_i         (sys_rst),
    .start_i       (start),
    .en_i          (state_q != IDLE),
    .phase_o       (phase),
    .phase_nxt_o   (phase_nxt),
    .half_hi_o     (half_hi),
    .half_hi_nxt_o (half_hi_nxt),
    .period_end_o  (period_end)
  );

  // Frame sequencing: accept a start in IDLE, step bits on each period end, then latch
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shadow_d = shadow_q;
    start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load || auto_en) begin
          start    = 1'b1;
          state_d  = SHIFT;
          bit_d    = '0;
          shadow_d = data_in;
        end
      end
      SHIFT: begin
        if (period_end) begin
          if (bit_q == LAST_BIT) begin
            state_d = LATCH;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      LATCH: begin
        if (period_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values for the coming cycle, decoded from next state so every output is a flop
  always_comb begin
    ready_d = (state_d == IDLE);
    done_d  = (state_q == LATCH) && period_end;
    shcp_d  = (state_d == SHIFT) && half_hi_nxt;
    stcp_d  = (state_d == LATCH) && half_hi_nxt;
    oe_n_d  = done_d ? 1'b0 : oe_n_q;
    case (state_d)
      SHIFT:   ds_d = MSB_FIRST ? shadow_d[LAST_BIT - bit_d] : shadow_d[bit_d];
      LATCH:   ds_d = ds_q;
      default: ds_d = 1'b0;
    endcase
  end

  // State, counters, shadow frame and registered pins
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      shadow_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      shcp_q   <= 1'b0;
      stcp_q   <= 1'b0;
      ds_q     <= 1'b0;
      oe_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      shcp_q   <= shcp_d;
      stcp_q   <= stcp_d;
      ds_q     <= ds_d;
      oe_n_q   <= oe_n_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign shcp  = shcp_q;
  assign stcp  = stcp_q;
  assign ds    = ds_q;
  assign oe_n  = oe_n_q;

endmodule
